cla_pipe: RTL and testbench
===========================

# cla_pipe

Parametrised, pipelined carry-lookahead adder/subtractor, next generation of the team's fixed 32-bit four-block CLA. Operand width and lookahead-block width are parameters. Each lookahead block occupies its own pipeline stage, with the inter-block carry registered. Sits between the ALU operand latches and the writeback mux, and accepts one operation per cycle under a valid/ready handshake.

## Interface
- `WIDTH`, default 32: operand and sum width. Must be a multiple of `BLOCK`.
- `BLOCK`, default 8: bits per lookahead block. `STAGES = WIDTH/BLOCK` (default 4).
- `clock`  in  1: sole clock; all state updates on the rising edge.
- `reset_n`  in  1: synchronous, active-low reset; sampled on the rising edge of `clock`.
- `in_valid`  in  1: operands and mode are valid this cycle.
- `in_ready`  out  1: block accepts an operation this cycle.
- `a`  in  WIDTH: operand A.
- `b`  in  WIDTH: operand B.
- `cin`  in  1: carry-in. Used only when `sub`=0.
- `sub`  in  1: 0 = A+B+cin; 1 = A-B, computed as A+~B+1.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: consumer takes result this cycle.
- `s`  out  WIDTH: sum/difference.
- `cout`  out  1: carry out of MSB. For subtract, 1 means no borrow.
- `ovf`  out  1: two's-complement overflow (see Configuration).
- `zero`  out  1: `s` == 0.

## Operation
- Transfer on input occurs when `in_valid && in_ready`. Transfer on output occurs when `out_valid && out_ready`.
- Stage k (0..STAGES-1) adds operand bits [k*BLOCK +: BLOCK] using the lookahead carry from stage k-1 (stage 0 uses `sub ? 1 : cin`), then registers:
  - the block's sum slice;
  - the block's carry-out;
  - the not-yet-consumed upper operand slices.
- Lower sum slices are carried forward (deskewed), so the full `s` appears together at the last stage.
- `sub` inverts all of B at stage-0 capture and travels with the operation.
- Each stage holds a valid bit. Global advance is `adv = !out_valid || out_ready`.
  - When `adv`=1, every stage shifts forward, and stage 0 loads the input if a transfer occurred; otherwise stage 0 loads a bubble.
  - When `adv`=0, all stages hold.
- `in_ready = adv`, combinational from `out_valid`/`out_ready`. `in_ready` has no dependency on `in_valid`.
- `zero` and `ovf` are computed in the final stage from the registered full result and registered MSB carries. They are valid whenever `out_valid`=1.
- No state machine beyond the valid shift register. Bubbles are not collapsed.

## Timing
- Latency: an operation accepted at edge N is presented with `out_valid`=1 after edge N+STAGES (default 4 cycles).
- Throughput: one operation per cycle while `out_ready`=1.
- Stall: with `out_valid`=1 and `out_ready`=0:
  - `in_ready`=0 in the same cycle;
  - `s`, `cout`, `ovf`, `zero` are held stable until the transfer.
- Simultaneous output transfer and input acceptance in one cycle is legal; no bubble is inserted.
- Reset (`reset_n`=0 at an edge):
  - all stage valids clear to 0; `out_valid`=0;
  - `s`=0, `cout`=0, `ovf`=0, `zero`=0;
  - in-flight operations are discarded. Reset mid-stall discards the held result.
  - `in_ready`=1 in the first cycle after reset deasserts.
- Wrap-around: sums wrap modulo 2^WIDTH. The carry out of the MSB goes to `cout` only.
- Data outputs are don't-care when `out_valid`=0 (except after reset).

## Configuration
- `CLA_PIPE_OVF_EN`
  - Defined: the last stage registers the carry into the MSB, and `ovf = c_msb_in ^ cout`.
  - Undefined: `ovf` is tied to 0, and the MSB-in carry register is not built.

## Test plan
- Reset, then 0x0000_0001 + 0xFFFF_FFFF, `cin`=0, `sub`=0, `out_ready`=1 → `out_valid` exactly 4 cycles later with `s`=0, `cout`=1, `zero`=1, `ovf`=0.
- 0x7FFF_FFFF + 0x0000_0001, `sub`=0 → `s`=0x8000_0000, `cout`=0, `ovf`=1 with macro defined, `ovf`=0 without.
- 5 − 7 (`sub`=1, `cin`=1 ignored) → `s`=0xFFFF_FFFE, `cout`=0; 7 − 5 → `s`=2, `cout`=1.
- Back-to-back stream of 16 random ops with `out_ready`=1 → 16 results, in order, on 16 consecutive cycles, each matching the model.
- Hold `out_ready`=0 for 3 cycles with a full pipeline:
  - `in_ready`=0 throughout and outputs stable;
  - on release, the remaining results drain in order with none lost or duplicated.
- Assert `reset_n`=0 with 3 operations in flight → the next cycle shows `out_valid`=0 and all outputs 0, and none of the 3 results ever appears.
- Parameter sweep `WIDTH`=16, `BLOCK`=4 → 4-cycle latency and correct 16-bit wrap: 0xFFFF+0x0001 gives `s`=0, `cout`=1.

Source files
------------

// File: rtl/cla_pipe_if.sv
// Operand/result bundle for cla_pipe: valid/ready operand side and valid/ready result side.
interface cla_pipe_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf, zero
    );
endinterface

// File: rtl/cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor, one BLOCK-wide lookahead block per stage.
// Define CLA_PIPE_OVF_EN to build the MSB-carry register and drive a real overflow flag.
module cla_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BLOCK = 8
) (
    input logic       clock,
    input logic       reset_n,
    cla_pipe_if.slave bus
);
    localparam int unsigned STAGES = WIDTH / BLOCK;

    if ((BLOCK == 0) || ((WIDTH % BLOCK) != 0)) begin : g_bad_cfg
        $error("cla_pipe: WIDTH must be a non-zero multiple of BLOCK");
    end

    // Parallel-prefix carries for one block; returns {carry into block MSB, carry out, sum}.
    function automatic logic [BLOCK+1:0] cla_block(input logic [BLOCK-1:0] x,
                                                   input logic [BLOCK-1:0] y,
                                                   input logic             c0);
        logic [BLOCK-1:0] p;
        logic [BLOCK-1:0] g;
        logic [BLOCK:0]   c;
        logic             prop;
        p    = x ^ y;
        g    = x & y;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < int'(BLOCK); i++) begin
            prop     = 1'b1;
            c[i+1]   = 1'b0;
            for (int j = i; j >= 0; j--) begin
                c[i+1] = c[i+1] | (g[j] & prop);
                prop   = prop & p[j];
            end
            c[i+1] = c[i+1] | (prop & c0);
        end
        return {c[BLOCK-1], c[BLOCK], p ^ c[BLOCK-1:0]};
    endfunction

    logic             adv;
    logic             ovld_q, ovld_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    assign adv = !ovld_q || bus.out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             v_in;
        logic             c_in;
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] sum_in;
        logic [BLOCK+1:0] blk;
        logic [WIDTH-1:0] sum_d;
        logic [WIDTH-1:0] sum_q;
        logic [WIDTH-1:0] opa_q;
        logic [WIDTH-1:0] opb_q;
        logic             vld_q;
        logic             cy_q;
        logic             unused_stage;

        if (k == 0) begin : g_head
            // Subtract folds into the first stage: invert B and force carry-in.
            assign v_in   = bus.in_valid;
            assign a_in   = bus.a;
            assign b_in   = bus.sub ? ~bus.b : bus.b;
            assign c_in   = bus.sub | bus.cin;
            assign sum_in = '0;
        end else begin : g_body
            assign v_in   = g_stage[k-1].vld_q;
            assign a_in   = g_stage[k-1].opa_q;
            assign b_in   = g_stage[k-1].opb_q;
            assign c_in   = g_stage[k-1].cy_q;
            assign sum_in = g_stage[k-1].sum_q;
        end

        assign blk = cla_block(a_in[k*BLOCK +: BLOCK], b_in[k*BLOCK +: BLOCK], c_in);

        always_comb begin
            sum_d                     = sum_in;
            sum_d[k*BLOCK +: BLOCK]   = blk[BLOCK-1:0];
        end

        always_ff @(posedge clock) begin
            if (!reset_n) begin
                vld_q <= 1'b0;
            end else if (adv) begin
                vld_q <= v_in;
            end
        end

        // Payload only moves with a real operation, so bubbles leave it untouched.
        always_ff @(posedge clock) begin
            if (adv && v_in) begin
                sum_q <= sum_d;
                cy_q  <= blk[BLOCK];
                opa_q <= a_in;
                opb_q <= b_in;
            end
        end

        assign unused_stage = ^{opa_q, opb_q, blk[BLOCK+1]};
    end

    logic             last_vld;
    logic             last_cy;
    logic [WIDTH-1:0] last_sum;

    assign last_vld = g_stage[STAGES-1].vld_q;
    assign last_cy  = g_stage[STAGES-1].cy_q;
    assign last_sum = g_stage[STAGES-1].sum_q;

`ifdef CLA_PIPE_OVF_EN
    logic cmsb_q;

    always_ff @(posedge clock) begin
        if (adv && g_stage[STAGES-1].v_in) begin
            cmsb_q <= g_stage[STAGES-1].blk[BLOCK+1];
        end
    end
`endif

    // Result register: flags derive from the registered full sum and MSB carries.
    always_comb begin
        ovld_d = ovld_q;
        s_d    = s_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        zero_d = zero_q;
        if (adv) begin
            ovld_d = last_vld;
            if (last_vld) begin
                s_d    = last_sum;
                cout_d = last_cy;
                zero_d = (last_sum == '0);
`ifdef CLA_PIPE_OVF_EN
                ovf_d  = cmsb_q ^ last_cy;
`else
                ovf_d  = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ovld_q <= 1'b0;
            s_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            ovld_q <= ovld_d;
            s_q    <= s_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = ovld_q;
    assign bus.s         = s_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_cla_pipe.sv
// Directed self-checking bench for cla_pipe: 32/8 instance for function and handshake, 16/4 for the sweep.
module tb_cla_pipe;
    logic clock = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_err    = 0;

    cla_pipe_if #(.WIDTH(32)) bus32 ();
    cla_pipe_if #(.WIDTH(16)) bus16 ();

    cla_pipe #(.WIDTH(32), .BLOCK(8)) dut32 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus32.slave)
    );

    cla_pipe #(.WIDTH(16), .BLOCK(4)) dut16 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus16.slave)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [33:0] exp_q [$];
    logic [31:0] va [24];
    logic [31:0] vb [24];
    logic        vcin [24];
    logic        vsub [24];

    // Reference: {ovf, cout, s} from plain wide arithmetic.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        logic [31:0] bb;
        logic [32:0] r;
        logic        o;
        bb = sub ? ~b : b;
        r  = {1'b0, a} + {1'b0, bb} + 33'(sub ? 1'b1 : cin);
`ifdef CLA_PIPE_OVF_EN
        o  = (a[31] == bb[31]) && (r[31] != a[31]);
`else
        o  = 1'b0;
`endif
        return {o, r};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int i);
        bus32.a   = va[i];
        bus32.b   = vb[i];
        bus32.cin = vcin[i];
        bus32.sub = vsub[i];
    endtask

    // One handshake cycle on the 32-bit instance with scoreboard update.
    task automatic cycle(output logic acc, output logic took);
        logic [33:0] e;
        #1;
        acc  = bus32.in_valid && bus32.in_ready;
        took = bus32.out_valid && bus32.out_ready;
        if (acc) exp_q.push_back(model(bus32.a, bus32.b, bus32.cin, bus32.sub));
        if (took) begin
            check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_s", bus32.s, e[31:0]);
                check("sb_cout", 32'(bus32.cout), 32'(e[32]));
                check("sb_ovf", 32'(bus32.ovf), 32'(e[33]));
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic op_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic cin, input logic sub, input logic [31:0] es,
                            input logic ec, input logic eo_def, input logic ez);
        int   n;
        logic eo;
`ifdef CLA_PIPE_OVF_EN
        eo = eo_def;
`else
        eo = 1'b0;
`endif
        bus32.a        = a;
        bus32.b        = b;
        bus32.cin      = cin;
        bus32.sub      = sub;
        bus32.in_valid = 1'b1;
        tick();
        bus32.in_valid = 1'b0;
        n = 0;
        while (bus32.out_valid !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'd4);
        check({tag, "_s"}, bus32.s, es);
        check({tag, "_cout"}, 32'(bus32.cout), 32'(ec));
        check({tag, "_ovf"}, 32'(bus32.ovf), 32'(eo));
        check({tag, "_zero"}, 32'(bus32.zero), 32'(ez));
    endtask

    task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] es, input logic ec, input logic eo_def,
                        input logic ez);
        int   n;
        logic eo;
`ifdef CLA_PIPE_OVF_EN
        eo = eo_def;
`else
        eo = 1'b0;
`endif
        bus16.a        = a;
        bus16.b        = b;
        bus16.cin      = 1'b0;
        bus16.sub      = 1'b0;
        bus16.in_valid = 1'b1;
        tick();
        bus16.in_valid = 1'b0;
        n = 0;
        while (bus16.out_valid !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'd4);
        check({tag, "_s"}, 32'(bus16.s), 32'(es));
        check({tag, "_cout"}, 32'(bus16.cout), 32'(ec));
        check({tag, "_ovf"}, 32'(bus16.ovf), 32'(eo));
        check({tag, "_zero"}, 32'(bus16.zero), 32'(ez));
    endtask

    initial begin
        logic acc;
        logic took;
        int   nxt;
        int   ntake;

        for (int i = 0; i < 24; i++) begin
            va[i]   = (32'(i) * 32'h9E37_79B9) ^ 32'h0F1E_2D3C;
            vb[i]   = 32'(i * 7 + 3) * 32'h85EB_CA6B;
            vcin[i] = i[1];
            vsub[i] = i[0];
        end
        va[2] = 32'h7FFF_FFFF;
        vb[2] = 32'h0000_0001;

        reset_n         = 1'b0;
        bus32.in_valid  = 1'b0;
        bus32.a         = '0;
        bus32.b         = '0;
        bus32.cin       = 1'b0;
        bus32.sub       = 1'b0;
        bus32.out_ready = 1'b1;
        bus16.in_valid  = 1'b0;
        bus16.a         = '0;
        bus16.b         = '0;
        bus16.cin       = 1'b0;
        bus16.sub       = 1'b0;
        bus16.out_ready = 1'b1;
        tick();
        tick();

        check("rst_valid", 32'(bus32.out_valid), 32'd0);
        check("rst_s", bus32.s, 32'd0);
        check("rst_cout", 32'(bus32.cout), 32'd0);
        check("rst_ovf", 32'(bus32.ovf), 32'd0);
        check("rst_zero", 32'(bus32.zero), 32'd0);
        reset_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(bus32.in_ready), 32'd1);

        op_check("wrap",     32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        op_check("ovf_pos",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        op_check("sub_5m7",  32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        op_check("sub_7m5",  32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
        op_check("sub_min",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        op_check("cin_blk",  32'h00FF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0);
        op_check("ovf_neg",  32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
        op_check("sub_self", 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        tick();
        check("drain_valid", 32'(bus32.out_valid), 32'd0);

        // Back-to-back stream: results must occupy 16 consecutive cycles.
        ntake = 0;
        for (int c = 0; c < 24; c++) begin
            if (c < 16) begin
                drive(c);
                bus32.in_valid = 1'b1;
            end else begin
                bus32.in_valid = 1'b0;
            end
            cycle(acc, took);
            if (took) ntake++;
            check("stream_slot", 32'(took), 32'((c >= 5) && (c <= 20)));
        end
        check("stream_count", 32'(ntake), 32'd16);
        check("stream_q_empty", 32'(exp_q.size()), 32'd0);

        // Fill the pipe, then stall the consumer for three cycles.
        nxt = 0;
        for (int c = 0; c < 6; c++) begin
            drive(16 + nxt);
            bus32.in_valid = 1'b1;
            cycle(acc, took);
            check("fill_acc", 32'(acc), 32'd1);
            if (acc) nxt++;
        end
        bus32.out_ready = 1'b0;
        drive(16 + nxt);
        bus32.in_valid = 1'b1;
        for (int st = 0; st < 3; st++) begin
            logic [33:0] h;
            h = model(va[17], vb[17], vcin[17], vsub[17]);
            #1;
            check("stall_in_ready", 32'(bus32.in_ready), 32'd0);
            check("stall_valid", 32'(bus32.out_valid), 32'd1);
            check("stall_s", bus32.s, h[31:0]);
            check("stall_cout", 32'(bus32.cout), 32'(h[32]));
            check("stall_ovf", 32'(bus32.ovf), 32'(h[33]));
            @(posedge clock);
            #1;
        end
        bus32.out_ready = 1'b1;
        ntake = 0;
        for (int c = 0; c < 16; c++) begin
            if (nxt < 8) begin
                drive(16 + nxt);
                bus32.in_valid = 1'b1;
            end else begin
                bus32.in_valid = 1'b0;
            end
            cycle(acc, took);
            if (acc) nxt++;
            if (took) ntake++;
        end
        check("drain_sent", 32'(nxt), 32'd8);
        check("drain_count", 32'(ntake), 32'd7);
        check("drain_q_empty", 32'(exp_q.size()), 32'd0);

        // Reset with three operations in flight; none may surface afterwards.
        for (int i = 0; i < 3; i++) begin
            bus32.a        = 32'hDEAD_0000 + 32'(i);
            bus32.b        = 32'h0000_0000;
            bus32.cin      = 1'b0;
            bus32.sub      = 1'b0;
            bus32.in_valid = 1'b1;
            tick();
        end
        bus32.in_valid = 1'b0;
        reset_n        = 1'b0;
        tick();
        check("rinf_valid", 32'(bus32.out_valid), 32'd0);
        check("rinf_s", bus32.s, 32'd0);
        check("rinf_cout", 32'(bus32.cout), 32'd0);
        check("rinf_ovf", 32'(bus32.ovf), 32'd0);
        check("rinf_zero", 32'(bus32.zero), 32'd0);
        reset_n = 1'b1;
        #1;
        check("rinf_in_ready", 32'(bus32.in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rinf_gone", 32'(bus32.out_valid), 32'd0);
        end

        op16("w16_wrap", 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);
        op16("w16_ovf",  16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
